// File: rtl/branch_update_queue_if.sv
// Resolved-branch input bus and predictor update output bus of branch_update_queue.
// The producer/consumer side uses the master modport; the queue uses the slave modport.
interface branch_update_queue_if #(
    parameter int ENTRY_NUM   = 8,
    parameter int INDEX_WIDTH = 10,
    parameter int HIST_WIDTH  = 10,
    parameter int CTR_WIDTH   = 2
);
    localparam int COUNT_WIDTH = $clog2(ENTRY_NUM) + 1;

    logic [1:0]                  inValid;
    logic [1:0][INDEX_WIDTH-1:0] inIndex;
    logic [1:0][HIST_WIDTH-1:0]  inHist;
    logic [1:0][CTR_WIDTH-1:0]   inCtr;
    logic [1:0]                  inTaken;
    logic [1:0]                  inMispred;
    logic [1:0]                  inIsCondBr;
    logic                        inReady;

    logic                        outValid;
    logic                        outReady;
    logic [INDEX_WIDTH-1:0]      outIndex;
    logic [HIST_WIDTH-1:0]       outCtrSel;
    logic [CTR_WIDTH-1:0]        outCtrValue;
    logic                        outHistWE;
    logic [HIST_WIDTH-1:0]       outHistValue;

    logic [COUNT_WIDTH-1:0]      count;
    logic [15:0]                 dropCount;

    modport master (
        output inValid, inIndex, inHist, inCtr, inTaken, inMispred, inIsCondBr, outReady,
        input  inReady, outValid, outIndex, outCtrSel, outCtrValue, outHistWE, outHistValue,
        input  count, dropCount
    );

    modport slave (
        input  inValid, inIndex, inHist, inCtr, inTaken, inMispred, inIsCondBr, outReady,
        output inReady, outValid, outIndex, outCtrSel, outCtrValue, outHistWE, outHistValue,
        output count, dropCount
    );
endinterface

// File: rtl/branch_update_queue.sv
// Branch update queue: buffers up to two resolved branches per cycle and feeds counter and
// history updates to the predictor in order. Optional macro BR_UPDATE_QUEUE_MERGE_EN merges same-entry slots.
module branch_update_queue #(
    parameter int ENTRY_NUM   = 8,
    parameter int INDEX_WIDTH = 10,
    parameter int HIST_WIDTH  = 10,
    parameter int CTR_WIDTH   = 2
) (
    input logic                  clk,
    input logic                  rst,
    branch_update_queue_if.slave bus
);
    localparam int PTR_WIDTH   = $clog2(ENTRY_NUM);
    localparam int COUNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CTR_WIDTH-1:0]   CTR_MAX     = {CTR_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] READY_LIMIT = COUNT_WIDTH'(ENTRY_NUM - 2);

    typedef struct packed {
        logic [INDEX_WIDTH-1:0] index;
        logic [HIST_WIDTH-1:0]  ctrSel;
        logic [CTR_WIDTH-1:0]   ctrValue;
        logic                   histWE;
        logic [HIST_WIDTH-1:0]  histValue;
    } entry_t;

    function automatic logic [CTR_WIDTH-1:0] updateCtr(input logic [CTR_WIDTH-1:0] ctr,
                                                       input logic taken);
        logic [CTR_WIDTH-1:0] result;
        if (taken) begin
            result = (ctr == CTR_MAX) ? CTR_MAX : ctr + CTR_WIDTH'(1);
        end else begin
            result = (ctr == '0) ? '0 : ctr - CTR_WIDTH'(1);
        end
        return result;
    endfunction

    function automatic entry_t makeEntry(input logic [INDEX_WIDTH-1:0] index,
                                         input logic [HIST_WIDTH-1:0]  hist,
                                         input logic [CTR_WIDTH-1:0]   ctr,
                                         input logic taken, input logic mispred, input logic isCondBr);
        entry_t e;
        e.index     = index;
        e.ctrSel    = hist;
        e.ctrValue  = updateCtr(ctr, taken);
        e.histWE    = mispred & isCondBr;
        e.histValue = {hist[HIST_WIDTH-2:0], taken};
        return e;
    endfunction

    entry_t                 mem_r [ENTRY_NUM];
    logic [PTR_WIDTH-1:0]   head_r;
    logic [PTR_WIDTH-1:0]   tail_r;
    logic [COUNT_WIDTH-1:0] count_r;
    logic [15:0]            dropCount_r;

    entry_t [1:0]           slotEntry_s;
    entry_t [1:0]           wrEntry_s;
    entry_t                 headEntry_s;
    logic [1:0]             pushNum_s;
    logic [1:0]             acceptNum_s;
    logic [1:0]             dropInc_s;
    logic [16:0]            dropSum_s;
    logic [15:0]            dropNext_s;
    logic                   mergeHit_s;
    logic                   inReady_s;
    logic                   outValid_s;
    logic                   pop_s;

    assign inReady_s  = (count_r <= READY_LIMIT);
    assign outValid_s = (count_r != '0);
    assign pop_s      = outValid_s & bus.outReady;
    assign dropInc_s  = {1'b0, bus.inValid[0]} + {1'b0, bus.inValid[1]};
    assign dropSum_s  = {1'b0, dropCount_r} + {15'd0, dropInc_s};
    assign dropNext_s = dropSum_s[16] ? 16'hFFFF : dropSum_s[15:0];

`ifdef BR_UPDATE_QUEUE_MERGE_EN
    assign mergeHit_s = (bus.inValid == 2'b11) &&
                        (bus.inIndex[0] == bus.inIndex[1]) &&
                        (bus.inHist[0] == bus.inHist[1]);
`else
    assign mergeHit_s = 1'b0;
`endif

    // Per-slot entry images built from the resolved-branch inputs.
    always_comb begin
        slotEntry_s[0] = makeEntry(bus.inIndex[0], bus.inHist[0], bus.inCtr[0],
                                   bus.inTaken[0], bus.inMispred[0], bus.inIsCondBr[0]);
        slotEntry_s[1] = makeEntry(bus.inIndex[1], bus.inHist[1], bus.inCtr[1],
                                   bus.inTaken[1], bus.inMispred[1], bus.inIsCondBr[1]);
    end

    // Compact valid slots into write ports 0/1; a lone slot always lands in port 0.
    always_comb begin
        wrEntry_s = slotEntry_s;
        pushNum_s = 2'd0;
        if (mergeHit_s) begin
            wrEntry_s[0]          = slotEntry_s[1];
            wrEntry_s[0].ctrValue = updateCtr(updateCtr(bus.inCtr[0], bus.inTaken[0]), bus.inTaken[1]);
            wrEntry_s[0].histWE   = slotEntry_s[0].histWE | slotEntry_s[1].histWE;
            pushNum_s             = 2'd1;
        end else if (bus.inValid == 2'b11) begin
            pushNum_s = 2'd2;
        end else if (bus.inValid == 2'b10) begin
            wrEntry_s[0] = slotEntry_s[1];
            pushNum_s    = 2'd1;
        end else if (bus.inValid == 2'b01) begin
            pushNum_s = 2'd1;
        end else begin
            pushNum_s = 2'd0;
        end
    end

    // Pushes are all-or-nothing per cycle: either both slots fit or every valid slot is dropped.
    always_comb begin
        if (inReady_s) begin
            acceptNum_s = pushNum_s;
        end else begin
            acceptNum_s = 2'd0;
        end
    end

    // Pointer, occupancy and drop-counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r      <= '0;
            tail_r      <= '0;
            count_r     <= '0;
            dropCount_r <= 16'd0;
        end else begin
            if (pop_s) begin
                head_r <= head_r + PTR_WIDTH'(1);
            end
            tail_r  <= tail_r + PTR_WIDTH'(acceptNum_s);
            count_r <= count_r + COUNT_WIDTH'(acceptNum_s) - COUNT_WIDTH'(pop_s);
            if (!inReady_s) begin
                dropCount_r <= dropNext_s;
            end
        end
    end

    // Entry storage; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (!rst && (acceptNum_s != 2'd0)) begin
            mem_r[tail_r] <= wrEntry_s[0];
            if (acceptNum_s == 2'd2) begin
                mem_r[tail_r + PTR_WIDTH'(1)] <= wrEntry_s[1];
            end
        end
    end

    // Head view is forced to zero when empty so stale storage never leaks out.
    always_comb begin
        if (outValid_s) begin
            headEntry_s = mem_r[head_r];
        end else begin
            headEntry_s = '0;
        end
    end

    assign bus.inReady      = inReady_s;
    assign bus.outValid     = outValid_s;
    assign bus.outIndex     = headEntry_s.index;
    assign bus.outCtrSel    = headEntry_s.ctrSel;
    assign bus.outCtrValue  = headEntry_s.ctrValue;
    assign bus.outHistWE    = headEntry_s.histWE;
    assign bus.outHistValue = headEntry_s.histValue;
    assign bus.count        = count_r;
    assign bus.dropCount    = dropCount_r;
endmodule

// File: tb/tb_branch_update_queue.sv
// Self-checking bench for branch_update_queue: scoreboard of expected head entries plus
// directed occupancy, drop, wrap, merge and reset scenarios.
module tb_branch_update_queue;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_update_queue_if bus ();
    branch_update_queue dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [9:0] idx;
        logic [9:0] sel;
        logic [1:0] ctr;
        logic       we;
        logic [9:0] hv;
    } ent_t;

    ent_t sbq[$];
    int   modelCount = 0;
    int   modelDrop  = 0;
    int   passCnt    = 0;
    int   totalCnt   = 0;

    function automatic logic [1:0] nextCtr(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    function automatic ent_t expEntry(input int s);
        ent_t e;
        e.idx = bus.inIndex[s];
        e.sel = bus.inHist[s];
        e.ctr = nextCtr(bus.inCtr[s], bus.inTaken[s]);
        e.we  = bus.inMispred[s] & bus.inIsCondBr[s];
        e.hv  = {bus.inHist[s][8:0], bus.inTaken[s]};
        return e;
    endfunction

    function automatic ent_t headObs();
        return {bus.outIndex, bus.outCtrSel, bus.outCtrValue, bus.outHistWE, bus.outHistValue};
    endfunction

    task automatic clearInputs();
        bus.inValid    = 2'b00;
        bus.inIndex    = '0;
        bus.inHist     = '0;
        bus.inCtr      = '0;
        bus.inTaken    = 2'b00;
        bus.inMispred  = 2'b00;
        bus.inIsCondBr = 2'b00;
    endtask

    task automatic setSlot(input int s, input logic [9:0] idx, input logic [9:0] hist,
                           input logic [1:0] ctr, input logic taken, input logic mis, input logic cond);
        bus.inValid[s]    = 1'b1;
        bus.inIndex[s]    = idx;
        bus.inHist[s]     = hist;
        bus.inCtr[s]      = ctr;
        bus.inTaken[s]    = taken;
        bus.inMispred[s]  = mis;
        bus.inIsCondBr[s] = cond;
    endtask

    task automatic setRandomSlot(input int s);
        setSlot(s, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // Advance one clock, updating the reference model; samples land 1 time unit after the edge.
    task automatic cycle();
        logic accept, doPop, merge;
        logic [1:0] v;
        int nValid;
        ent_t e0, e1, em;
        accept = ((8 - modelCount) >= 2);
        doPop  = (modelCount != 0) && bus.outReady;
        v      = bus.inValid;
        nValid = int'(bus.inValid[0]) + int'(bus.inValid[1]);
        e0     = expEntry(0);
        e1     = expEntry(1);
        em     = e1;
        em.ctr = nextCtr(nextCtr(bus.inCtr[0], bus.inTaken[0]), bus.inTaken[1]);
        em.we  = e0.we | e1.we;
        merge  = 1'b0;
`ifdef BR_UPDATE_QUEUE_MERGE_EN
        merge = (v == 2'b11) && (bus.inIndex[0] == bus.inIndex[1]) && (bus.inHist[0] == bus.inHist[1]);
`endif
        @(posedge clk);
        if (rst) begin
            sbq.delete();
            modelDrop = 0;
        end else begin
            if (doPop) void'(sbq.pop_front());
            if (!accept) begin
                modelDrop = (modelDrop + nValid > 65535) ? 65535 : modelDrop + nValid;
            end else if (merge) begin
                sbq.push_back(em);
            end else begin
                if (v[0]) sbq.push_back(e0);
                if (v[1]) sbq.push_back(e1);
            end
        end
        modelCount = sbq.size();
        #1;
    endtask

    task automatic test_reset();
        totalCnt++;
        if ({bus.count, bus.outValid, bus.inReady, bus.dropCount, bus.outHistWE} !== {4'd0, 1'b0, 1'b1, 16'd0, 1'b0})
            $display("FAIL reset_state: got count=%0d outValid=%b inReady=%b drop=%0d histWE=%b, expected 0/0/1/0/0",
                     bus.count, bus.outValid, bus.inReady, bus.dropCount, bus.outHistWE);
        else passCnt++;
    endtask

    task automatic test_saturate();
        bus.outReady = 1'b0;
        setSlot(0, 10'd5, 10'd3, 2'd3, 1'b1, 1'b0, 1'b0);
        totalCnt++;
        if (bus.outValid !== 1'b0) $display("FAIL no_bypass: got outValid=%b expected 0", bus.outValid);
        else passCnt++;
        cycle();
        clearInputs();
        totalCnt++;
        if ({bus.outValid, bus.outIndex, bus.outCtrSel, bus.outCtrValue} !== {1'b1, 10'd5, 10'd3, 2'd3})
            $display("FAIL saturate_head: got v=%b idx=%0d sel=%0d ctr=%0d expected 1/5/3/3",
                     bus.outValid, bus.outIndex, bus.outCtrSel, bus.outCtrValue);
        else passCnt++;
        cycle();
        totalCnt++;
        if (headObs() !== sbq[0]) $display("FAIL hold_stable: got %h expected %h", headObs(), sbq[0]);
        else passCnt++;
        bus.outReady = 1'b1;
        for (int g = 0; g < 20 && modelCount != 0; g++) begin
            totalCnt++;
            if (headObs() !== sbq[0]) $display("FAIL saturate_drain: got %h expected %h", headObs(), sbq[0]);
            else passCnt++;
            cycle();
        end
        bus.outReady = 1'b0;
    endtask

    task automatic test_mispred();
        setSlot(1, 10'd9, 10'h155, 2'd0, 1'b0, 1'b1, 1'b1);
        cycle();
        clearInputs();
        totalCnt++;
        if ({bus.outCtrValue, bus.outHistWE, bus.outHistValue, bus.count} !== {2'd0, 1'b1, 10'h2AA, 4'd1})
            $display("FAIL mispred_entry: got ctr=%0d we=%b hist=%h count=%0d expected 0/1/2aa/1",
                     bus.outCtrValue, bus.outHistWE, bus.outHistValue, bus.count);
        else passCnt++;
        bus.outReady = 1'b1;
        cycle();
        bus.outReady = 1'b0;
        totalCnt++;
        if ({bus.outValid, headObs()} !== {1'b0, 33'd0})
            $display("FAIL empty_outputs: got v=%b head=%h expected all zero", bus.outValid, headObs());
        else passCnt++;
    endtask

    task automatic test_fill_drop();
        bus.outReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            setRandomSlot(0);
            setRandomSlot(1);
            cycle();
            clearInputs();
        end
        totalCnt++;
        if ({bus.count, bus.inReady} !== {4'd6, 1'b1})
            $display("FAIL fill_six: got count=%0d inReady=%b expected 6/1", bus.count, bus.inReady);
        else passCnt++;
        setRandomSlot(0);
        cycle();
        clearInputs();
        totalCnt++;
        if ({bus.count, bus.inReady} !== {4'd7, 1'b0})
            $display("FAIL fill_seven: got count=%0d inReady=%b expected 7/0", bus.count, bus.inReady);
        else passCnt++;
        for (int k = 0; k < 2; k++) begin
            setRandomSlot(0);
            setRandomSlot(1);
            cycle();
            clearInputs();
            totalCnt++;
            if ({bus.dropCount, bus.count} !== {16'(modelDrop), 4'd7})
                $display("FAIL drop_count: got drop=%0d count=%0d expected %0d/7", bus.dropCount, bus.count, modelDrop);
            else passCnt++;
        end
        totalCnt++;
        if (bus.dropCount !== 16'd4) $display("FAIL drop_total: got %0d expected 4", bus.dropCount);
        else passCnt++;
    endtask

    task automatic test_wrap();
        bus.outReady = 1'b1;
        totalCnt++;
        if (headObs() !== sbq[0]) $display("FAIL wrap_first: got %h expected %h", headObs(), sbq[0]);
        else passCnt++;
        cycle();
        for (int k = 0; k < 20; k++) begin
            setRandomSlot(0);
            totalCnt++;
            if (headObs() !== sbq[0]) $display("FAIL wrap_order: got %h expected %h", headObs(), sbq[0]);
            else passCnt++;
            cycle();
            clearInputs();
            totalCnt++;
            if (bus.count !== 4'd6) $display("FAIL wrap_count: got %0d expected 6", bus.count);
            else passCnt++;
        end
        for (int g = 0; g < 20 && modelCount != 0; g++) begin
            totalCnt++;
            if (headObs() !== sbq[0]) $display("FAIL wrap_drain: got %h expected %h", headObs(), sbq[0]);
            else passCnt++;
            cycle();
        end
        bus.outReady = 1'b0;
        totalCnt++;
        if ({bus.count, bus.outValid} !== {4'd0, 1'b0})
            $display("FAIL wrap_empty: got count=%0d v=%b expected 0/0", bus.count, bus.outValid);
        else passCnt++;
    endtask

    task automatic test_back_to_back();
        bus.outReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            setRandomSlot(0);
            setRandomSlot(1);
            if (modelCount != 0) begin
                totalCnt++;
                if (headObs() !== sbq[0]) $display("FAIL b2b_order: got %h expected %h", headObs(), sbq[0]);
                else passCnt++;
            end
            cycle();
            clearInputs();
            totalCnt++;
            if (bus.count !== 4'(modelCount))
                $display("FAIL b2b_count: got %0d expected %0d", bus.count, modelCount);
            else passCnt++;
        end
        for (int g = 0; g < 20 && modelCount != 0; g++) begin
            totalCnt++;
            if (headObs() !== sbq[0]) $display("FAIL b2b_drain: got %h expected %h", headObs(), sbq[0]);
            else passCnt++;
            cycle();
        end
        bus.outReady = 1'b0;
    endtask

    task automatic test_merge();
        bus.outReady = 1'b0;
        setSlot(0, 10'd7, 10'd1, 2'd1, 1'b1, 1'b0, 1'b0);
        setSlot(1, 10'd7, 10'd1, 2'd1, 1'b1, 1'b0, 1'b0);
        cycle();
        clearInputs();
`ifdef BR_UPDATE_QUEUE_MERGE_EN
        totalCnt++;
        if ({bus.count, bus.outCtrValue} !== {4'd1, 2'd3})
            $display("FAIL merge_one: got count=%0d ctr=%0d expected 1/3", bus.count, bus.outCtrValue);
        else passCnt++;
`else
        totalCnt++;
        if ({bus.count, bus.outCtrValue} !== {4'd2, 2'd2})
            $display("FAIL merge_two: got count=%0d ctr=%0d expected 2/2", bus.count, bus.outCtrValue);
        else passCnt++;
`endif
        bus.outReady = 1'b1;
        for (int g = 0; g < 20 && modelCount != 0; g++) begin
            totalCnt++;
            if ({bus.outIndex, bus.outCtrValue, headObs()} !== {sbq[0].idx, sbq[0].ctr, sbq[0]})
                $display("FAIL merge_drain: got %h expected %h", headObs(), sbq[0]);
            else passCnt++;
            cycle();
        end
        bus.outReady = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.outReady = 1'b0;
        setRandomSlot(0); setRandomSlot(1); cycle(); clearInputs();
        setRandomSlot(0); setRandomSlot(1); cycle(); clearInputs();
        setRandomSlot(1); cycle(); clearInputs();
        totalCnt++;
        if (bus.count !== 4'd5) $display("FAIL pre_reset_count: got %0d expected 5", bus.count);
        else passCnt++;
        setRandomSlot(0);
        setRandomSlot(1);
        bus.outReady = 1'b1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        clearInputs();
        bus.outReady = 1'b0;
        totalCnt++;
        if ({bus.count, bus.outValid, bus.dropCount, bus.inReady} !== {4'd0, 1'b0, 16'd0, 1'b1})
            $display("FAIL mid_reset: got count=%0d v=%b drop=%0d inReady=%b expected 0/0/0/1",
                     bus.count, bus.outValid, bus.dropCount, bus.inReady);
        else passCnt++;
        cycle();
        totalCnt++;
        if ({bus.count, bus.outValid} !== {4'd0, 1'b0})
            $display("FAIL reset_discard: got count=%0d v=%b expected 0/0", bus.count, bus.outValid);
        else passCnt++;
    endtask

    initial begin
        rst = 1'b1;
        bus.outReady = 1'b0;
        clearInputs();
        cycle();
        cycle();
        rst = 1'b0;
        test_reset();
        test_saturate();
        test_mispred();
        test_fill_drop();
        test_wrap();
        test_back_to_back();
        test_merge();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/branch_update_queue.md
BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

Interface
REQ-001 Parameter ENTRY_NUM, default 8, queue depth; power of two, >= 4.
REQ-002 Parameter INDEX_WIDTH, default 10, predictor table index width.
REQ-003 Parameter HIST_WIDTH, default 10, per-address history width.
REQ-004 Parameter CTR_WIDTH, default 2, saturating counter width; CTR_MAX = 2^CTR_WIDTH-1.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 inValid  in  2  per-slot resolved-branch valid, slot 0 older than slot 1.
REQ-008 inIndex  in  2xINDEX_WIDTH  table index of the branch, per slot.
REQ-009 inHist  in  2xHIST_WIDTH  history used at prediction, per slot.
REQ-010 inCtr  in  2xCTR_WIDTH  counter value read at prediction, per slot.
REQ-011 inTaken  in  2  executed direction, per slot.
REQ-012 inMispred  in  2  misprediction flag, per slot.
REQ-013 inIsCondBr  in  2  conditional-branch flag, per slot.
REQ-014 inReady  out  1  queue can accept two entries this cycle.
REQ-015 outValid  out  1  head entry valid.
REQ-016 outReady  in  1  predictor accepts head this cycle.
REQ-017 outIndex  out  INDEX_WIDTH  head table index.
REQ-018 outCtrSel  out  HIST_WIDTH  counter selector (= stored inHist).
REQ-019 outCtrValue  out  CTR_WIDTH  updated counter value.
REQ-020 outHistWE  out  1  history recovery write request.
REQ-021 outHistValue  out  HIST_WIDTH  recovered history.
REQ-022 count  out  $clog2(ENTRY_NUM)+1  current occupancy.
REQ-023 dropCount  out  16  saturating count of rejected slots.

Function
REQ-024 Storage SHALL be a circular FIFO with head/tail pointers wrapping modulo ENTRY_NUM.
REQ-025 inReady SHALL equal (ENTRY_NUM - count) >= 2, from registered count only.
REQ-026 When inReady, valid slots SHALL enqueue in slot order (slot 0 first); a lone valid slot 1 occupies one entry.
REQ-027 When !inReady, each valid slot SHALL be discarded and dropCount incremented per slot, saturating at 16'hFFFF.
REQ-028 Enqueued counter value SHALL be inTaken ? min(inCtr+1, CTR_MAX) : max(inCtr-1, 0).
REQ-029 outHistWE SHALL be stored as inMispred & inIsCondBr; outHistValue as {inHist[HIST_WIDTH-2:0], inTaken}.
REQ-030 outValid SHALL be count != 0; an entry written at edge N SHALL be visible at head no earlier than N+1 (no bypass).
REQ-031 Pop SHALL occur on outValid & outReady; outputs SHALL hold stable while outValid & !outReady.
REQ-032 Simultaneous push and pop SHALL update count by (pushes - pop) in the same edge.
REQ-033 Outputs SHALL be driven from the head entry; when !outValid, outHistWE SHALL be 0 and other outputs 0.

Reset
REQ-034 On rst: head, tail, count, dropCount SHALL be 0; outValid 0; inReady 1 in the following cycle.
REQ-035 rst SHALL override simultaneous push/pop; inputs presented in the rst cycle SHALL be discarded without counting drops.
REQ-036 Entry storage contents need not be reset.

Configuration
REQ-037 Macro BR_UPDATE_QUEUE_MERGE_EN: when defined, two same-cycle valid slots with equal inIndex and inHist SHALL merge into one entry whose counter is the sequential application of slot 0 then slot 1 updates, with history fields taken from slot 1 and outHistWE the OR of both.
REQ-038 Without BR_UPDATE_QUEUE_MERGE_EN, such slots SHALL occupy two entries per REQ-026.

Verification
REQ-039 Reset, then slot0 {idx=5, hist=3, ctr=3, taken=1} -> next cycle outValid=1, outIndex=5, outCtrSel=3, outCtrValue=3 (saturated).
REQ-040 ctr=0, taken=0, mispred=1, condBr=1, hist=10'h155 -> outCtrValue=0, outHistWE=1, outHistValue=10'h2AA.
REQ-041 outReady=0, push 2/cycle for 4 cycles -> count=8, inReady=0 at count 7 or 8; extra pushes increment dropCount by 2 per cycle.
REQ-042 Fill, then outReady=1 with 1 push/cycle for 20 cycles -> FIFO order preserved across pointer wrap, count constant.
REQ-043 MERGE_EN defined, both slots idx=7 hist=1 ctr=1 taken=1,1 -> one entry, outCtrValue=3, count=1; undefined -> two entries with values 2, 2.
REQ-044 rst asserted with count=5 and valid inputs -> next cycle count=0, outValid=0, dropCount=0.
